// File: rtl/mem_access_stage_pkg.sv
// Shared types and widths for the memory-access stage of the MIPS pipeline.
package mem_access_stage_pkg;

    localparam int WORD_W = 32;
    localparam int REG_W  = 5;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    typedef struct packed {
        logic                     mem_to_reg;
        logic [REG_W-1:0]         write_reg;
        logic signed [WORD_W-1:0] alu_result;
    } ctrl_t;

endpackage

// File: rtl/mem_access_stage_mem_wait_timer.sv
// Loadable wait counter for an outstanding memory access; flags timeout once
// the count equals MAX_WAIT.
module mem_wait_timer #(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic             enable,
    input  logic [CNT_W-1:0] load_value,
    output logic             timeout
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign timeout = (count == CNT_W'(MAX_WAIT));

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage: issues loads/stores to word-addressed data memory via
// req/ack, stalls upstream while busy, and registers results for MEM/WB.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int MEM_DEPTH = 55001,
    parameter int MAX_WAIT  = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic                     in_mem_read,
    input  logic                     in_mem_write,
    input  logic                     in_mem_to_reg,
    input  logic signed [WORD_W-1:0] in_alu_result,
    input  logic signed [WORD_W-1:0] in_store_data,
    input  logic [REG_W-1:0]         in_write_reg,
    input  logic                     flush,
    output logic                     stall,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [WORD_W-1:0]        mem_addr,
    output logic [WORD_W-1:0]        mem_wdata,
    input  logic                     mem_ack,
    input  logic signed [WORD_W-1:0] mem_rdata,
    output logic                     out_valid,
    output logic                     out_mem_to_reg,
    output logic signed [WORD_W-1:0] out_read_data,
    output logic signed [WORD_W-1:0] out_alu_result,
    output logic [REG_W-1:0]         out_write_reg,
    output logic                     err
);

    state_t state, next_state;
    ctrl_t  ctrl_q;
    logic   load_q;
    logic   accept, is_mem, addr_ok;
    logic   start_mem, finish_plain, mem_done, mem_timeout;
    logic   timer_timeout;

    mem_wait_timer #(.MAX_WAIT(MAX_WAIT), .CNT_W(8)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .clear      (mem_done || mem_timeout),
        .load       (start_mem),
        .enable     (state == BUSY),
        .load_value (8'd1),
        .timeout    (timer_timeout)
    );

    assign stall   = (state == BUSY);
    assign mem_req = (state == BUSY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Negative addresses are out of range just like ones past the top.
    always_comb begin
        next_state   = state;
        start_mem    = 1'b0;
        finish_plain = 1'b0;
        mem_done     = 1'b0;
        mem_timeout  = 1'b0;
        accept       = in_valid && !flush;
        is_mem       = in_mem_read || in_mem_write;
        addr_ok      = !in_alu_result[WORD_W-1] && (in_alu_result < MEM_DEPTH);
        case (state)
            IDLE: begin
                if (accept) begin
                    if (is_mem && addr_ok) begin
                        start_mem  = 1'b1;
                        next_state = BUSY;
                    end else begin
                        finish_plain = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    mem_done   = 1'b1;
                    next_state = IDLE;
                end else if (timer_timeout) begin
                    mem_timeout = 1'b1;
                    next_state  = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q         <= '0;
            load_q         <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            out_valid      <= 1'b0;
            out_mem_to_reg <= 1'b0;
            out_read_data  <= '0;
            out_alu_result <= '0;
            out_write_reg  <= '0;
            err            <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (start_mem) begin
                mem_addr   <= in_alu_result;
                mem_wdata  <= in_store_data;
                mem_we     <= in_mem_write;
                load_q     <= in_mem_read && !in_mem_write;
                ctrl_q     <= '{mem_to_reg: in_mem_to_reg,
                                write_reg:  in_write_reg,
                                alu_result: in_alu_result};
            end
            if (finish_plain) begin
                out_valid      <= 1'b1;
                out_mem_to_reg <= in_mem_to_reg;
                out_alu_result <= in_alu_result;
                out_write_reg  <= in_write_reg;
                if (is_mem) begin
                    out_read_data <= '0;
                    err           <= 1'b1;
                end
            end
            // Completion of an outstanding access, by ack or by timeout.
            if (mem_done || mem_timeout) begin
                out_valid      <= 1'b1;
                out_mem_to_reg <= ctrl_q.mem_to_reg;
                out_alu_result <= ctrl_q.alu_result;
                out_write_reg  <= ctrl_q.write_reg;
                if (mem_timeout) begin
                    out_read_data <= '0;
                    err           <= 1'b1;
                end else if (load_q) begin
                    out_read_data <= mem_rdata;
                end
            end
        end
    end

endmodule
